// File: rtl/hesap_pkg.sv
// Shared definitions for the calculator arithmetic units: operation codes,
// the serial unit FSM states and the datapath widths.
package hesap_pkg;

    localparam logic [2:0] TUR_TOPLAMA = 3'b000;
    localparam logic [2:0] TUR_CIKARMA = 3'b001;

    localparam int VARSAYILAN_GENISLIK = 32;
    localparam int SONUC_GENISLIGI     = 64;

    typedef enum logic [1:0] {
        BOSTA   = 2'd0,
        HESAPLA = 2'd1,
        BITTI   = 2'd2
    } durum_t;

endpackage

// File: rtl/cikarma_seri_tam_cikarici.sv
// Combinational 1-bit full subtractor: d = a - b - borrow_in with borrow out.
module tam_cikarici (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic d,
    output logic borrow_out
);

    always_comb begin
        d          = a ^ b ^ borrow_in;
        borrow_out = (~a & b) | (~a & borrow_in) | (b & borrow_in);
    end

endmodule

// File: rtl/cikarma_seri.sv
// Bit-serial two's complement subtractor (sonuc = sayi1 - sayi2), LSB first,
// reporting completion with the same hazir/gecerli/tasma handshake as the adder.
module cikarma_seri
    import hesap_pkg::*;
#(
    parameter int         GENISLIK = VARSAYILAN_GENISLIK,
    parameter logic [2:0] TUR_KODU = TUR_CIKARMA
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       basla,
    input  logic [2:0]                 tur,
    input  logic [GENISLIK-1:0]        sayi1,
    input  logic [GENISLIK-1:0]        sayi2,
    output logic [SONUC_GENISLIGI-1:0] sonuc,
    output logic                       tasma,
    output logic                       odunc,
    output logic                       hazir,
    output logic                       gecerli,
    output logic                       mesgul
);

    localparam int SW = $clog2(GENISLIK) + 1;
    localparam logic [SW-1:0] SON_BIT = SW'(GENISLIK - 1);

    durum_t                     durum_q, durum_d;
    logic [GENISLIK-1:0]        a_q, a_d;
    logic [GENISLIK-1:0]        b_q, b_d;
    logic [GENISLIK-1:0]        fark_q, fark_d;
    logic [GENISLIK-1:0]        fark_yeni;
    logic                       borrow_q, borrow_d;
    logic [SW-1:0]              sayac_q, sayac_d;
    logic                       msb1_q, msb1_d;
    logic                       msb2_q, msb2_d;
    logic [SONUC_GENISLIGI-1:0] sonuc_q, sonuc_d;
    logic                       tasma_q, tasma_d;
    logic                       odunc_q, odunc_d;
    logic                       hazir_q, hazir_d;
    logic                       gecerli_q, gecerli_d;
    logic                       mesgul_q, mesgul_d;

    logic fark_bit;
    logic borrow_cikis;

    tam_cikarici u_tam_cikarici (
        .a          (a_q[0]),
        .b          (b_q[0]),
        .borrow_in  (borrow_q),
        .d          (fark_bit),
        .borrow_out (borrow_cikis)
    );

    always_comb begin
        durum_d   = durum_q;
        a_d       = a_q;
        b_d       = b_q;
        fark_d    = fark_q;
        borrow_d  = borrow_q;
        sayac_d   = sayac_q;
        msb1_d    = msb1_q;
        msb2_d    = msb2_q;
        sonuc_d   = sonuc_q;
        tasma_d   = tasma_q;
        odunc_d   = odunc_q;
        hazir_d   = hazir_q;
        gecerli_d = gecerli_q;
        mesgul_d  = mesgul_q;
        fark_yeni = {fark_bit, fark_q[GENISLIK-1:1]};

        unique case (durum_q)
            BOSTA: begin
                if (basla && (tur == TUR_KODU)) begin
                    a_d       = sayi1;
                    b_d       = sayi2;
                    msb1_d    = sayi1[GENISLIK-1];
                    msb2_d    = sayi2[GENISLIK-1];
                    fark_d    = '0;
                    borrow_d  = 1'b0;
                    sayac_d   = '0;
                    mesgul_d  = 1'b1;
                    gecerli_d = 1'b0;
                    durum_d   = HESAPLA;
                end
            end
            HESAPLA: begin
                fark_d   = fark_yeni;
                a_d      = {1'b0, a_q[GENISLIK-1:1]};
                b_d      = {1'b0, b_q[GENISLIK-1:1]};
                borrow_d = borrow_cikis;
                sayac_d  = sayac_q + SW'(1);
                // The last bit publishes the whole result in the same edge,
                // so sonuc never shows a partially shifted difference.
                if (sayac_q == SON_BIT) begin
                    sonuc_d   = SONUC_GENISLIGI'($signed(fark_yeni));
                    odunc_d   = borrow_cikis;
                    tasma_d   = (msb1_q != msb2_q) && (fark_bit != msb1_q);
                    hazir_d   = 1'b1;
                    gecerli_d = 1'b1;
                    mesgul_d  = 1'b0;
                    durum_d   = BITTI;
                end
            end
            BITTI: begin
                hazir_d = 1'b0;
                durum_d = BOSTA;
            end
            default: begin
                durum_d = BOSTA;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum_q   <= BOSTA;
            a_q       <= '0;
            b_q       <= '0;
            fark_q    <= '0;
            borrow_q  <= 1'b0;
            sayac_q   <= '0;
            msb1_q    <= 1'b0;
            msb2_q    <= 1'b0;
            sonuc_q   <= '0;
            tasma_q   <= 1'b0;
            odunc_q   <= 1'b0;
            hazir_q   <= 1'b0;
            gecerli_q <= 1'b0;
            mesgul_q  <= 1'b0;
        end else begin
            durum_q   <= durum_d;
            a_q       <= a_d;
            b_q       <= b_d;
            fark_q    <= fark_d;
            borrow_q  <= borrow_d;
            sayac_q   <= sayac_d;
            msb1_q    <= msb1_d;
            msb2_q    <= msb2_d;
            sonuc_q   <= sonuc_d;
            tasma_q   <= tasma_d;
            odunc_q   <= odunc_d;
            hazir_q   <= hazir_d;
            gecerli_q <= gecerli_d;
            mesgul_q  <= mesgul_d;
        end
    end

    assign sonuc   = sonuc_q;
    assign tasma   = tasma_q;
    assign odunc   = odunc_q;
    assign hazir   = hazir_q;
    assign gecerli = gecerli_q;
    assign mesgul  = mesgul_q;

endmodule
